instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  IF-stage producer for the IF/ID pipeline register. Owns the PC and runs the instruction-memory read handshake.
//  Supplies IF_Instruction/IF_PC/IF_PCAdd4/IF_IsBDS/IF_Stall to IF/ID. Applies branch-delay-slot and exception redirects.
// PARAMETERS
//  RESET_VECTOR  32'hBFC0_0000  PC loaded on reset; must be word aligned
// PORTS
//  clock             in   1   single clock; all state updates on posedge
//  reset             in   1   synchronous, active-high
//  ID_Stall          in   1   IF/ID register holds this cycle
//  ID_IsBranch       in   1   ID holds a branch/jump (taken or not); current IF instr is its delay slot
//  ID_BranchTaken    in   1   ID branch/jump redirects; valid only with ID_IsBranch
//  ID_BranchTarget   in   32  target for ID_BranchTaken
//  Exc_Redirect      in   1   exception/ERET redirect, highest priority
//  Exc_Target        in   32  vector for Exc_Redirect; always word aligned
//  InstMem_Read      out  1   read request; held with stable address until InstMem_Ready
//  InstMem_Address   out  30  word address = PC[31:2]
//  InstMem_Ready     in   1   read completes this cycle; InstMem_In valid
//  InstMem_In        in   32  read data
//  IF_Instruction    out  32  fetched instruction (32'b0 = NOP when not valid)
//  IF_PC             out  32  PC of IF_Instruction
//  IF_PCAdd4         out  32  IF_PC + 4, modulo 2^32
//  IF_IsBDS          out  1   IF_Instruction is a branch delay slot
//  IF_Stall          out  1   no valid instruction available to IF/ID this cycle
//  IF_AddrErr        out  1   IF_PC misaligned; instruction forced to 0; no memory read issued
// BEHAVIOUR
//  Reset: state REQ, PC=RESET_VECTOR, InstMem_Read=0 during reset.
//   IF_Instruction=0, IF_Stall=1, IF_IsBDS=0, IF_AddrErr=0.
//   Pending branch/BDS cleared. Any outstanding memory response is abandoned.
//  States:
//   REQ: InstMem_Read=1 (or AddrErr path), IF_Stall=1.
//   HOLD: captured instr valid, IF_Stall=0.
//   DISCARD: waiting out a stale read, InstMem_Read=1 at old address, IF_Stall=1.
//  REQ: on InstMem_Ready, capture InstMem_In into holding reg -> HOLD next cycle; minimum latency 1 cycle after Ready.
//   If PC[1:0]!=0: no read, IF_Instruction=0, IF_AddrErr=1 -> HOLD immediately.
//  HOLD: advance = !ID_Stall. On advance, PC <= next_pc -> REQ; otherwise hold all outputs stable.
//  next_pc priority: Exc_Target > pending/current branch target > PC+4.
//  Branch:
//   IF_IsBDS = ID_IsBranch | bds_pending.
//   If ID_IsBranch & !ID_Stall & !advance: set bds_pending; latch target if ID_BranchTaken.
//   Pending state clears on the delay slot's advance.
//   Branch and delay-slot advance in the same cycle: use ID_BranchTarget directly.
//  Exc_Redirect (any state, beats every other event in that cycle):
//   Clears pending branch/BDS; PC <= Exc_Target.
//   In REQ with read outstanding and no Ready this cycle -> DISCARD.
//   In REQ with Ready this cycle, or in HOLD: drop data -> REQ.
//  DISCARD: on InstMem_Ready, drop data -> REQ with new PC.
//   A second Exc_Redirect in DISCARD only updates PC.
//  Exc_Redirect and advance in the same cycle: exception wins; instr still hands to IF/ID (IF/ID flush kills it).
//  Throughput: 1 instr / 2 cycles with zero-wait memory; no prefetch.
// TESTING
//  Reset, zero-wait mem, ID_Stall=0 -> addresses BFC0_0000,_0004,_0008; each instr valid 1 cycle; IF_PCAdd4 = IF_PC+4.
//  ID_Stall=1 for 3 cycles in HOLD -> outputs frozen, InstMem_Read=0; release -> next addr issued next cycle.
//  Branch at 0x100 in ID, taken to 0x200, mem wait 2 cycles on slot -> slot 0x104 IF_IsBDS=1; next fetch 0x200.
//  Exc_Redirect to 0x8000_0180 during 3-wait read -> DISCARD; stale data never valid; next read 0x8000_0180.
//  Branch target 0x202 -> IF_AddrErr=1, IF_Instruction=0, no InstMem_Read; reset mid-read -> read drops, restart at RESET_VECTOR.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage owning the PC, the instruction-memory read handshake and branch/exception redirects
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ID_Stall,
  input  logic        ID_IsBranch,
  input  logic        ID_BranchTaken,
  input  logic [31:0] ID_BranchTarget,
  input  logic        Exc_Redirect,
  input  logic [31:0] Exc_Target,
  output logic        InstMem_Read,
  output logic [29:0] InstMem_Address,
  input  logic        InstMem_Ready,
  input  logic [31:0] InstMem_In,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCAdd4,
  output logic        IF_IsBDS,
  output logic        IF_Stall,
  output logic        IF_AddrErr
);
  typedef enum logic [1:0] {REQ, HOLD, DISCARD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, instr, instr_n, br_target, seq_pc, branch_pc;
  logic [29:0] stale_addr;
  logic bds_pending, br_taken, misaligned, advance;
  assign misaligned = |pc[1:0];
  assign advance = state == HOLD && !ID_Stall;
  assign seq_pc = pc + 32'd4;
  assign branch_pc = ID_IsBranch ? (ID_BranchTaken ? ID_BranchTarget : seq_pc)
                   : (bds_pending && br_taken) ? br_target : seq_pc;
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = instr;
    if (Exc_Redirect) begin
      pc_n = Exc_Target;
      state_n = ((state == REQ && !misaligned) || state == DISCARD) && !InstMem_Ready ? DISCARD : REQ;
    end else if (state == REQ && (misaligned || InstMem_Ready)) begin
      state_n = HOLD;
      instr_n = misaligned ? 32'd0 : InstMem_In;
    end else if (state == DISCARD && InstMem_Ready) begin
      state_n = REQ;
    end else if (advance) begin
      state_n = REQ;
      pc_n = branch_pc;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= REQ;
      pc <= RESET_VECTOR;
      instr <= '0;
      bds_pending <= 1'b0;
      br_taken <= 1'b0;
      br_target <= '0;
      stale_addr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      instr <= instr_n;
      if (state != DISCARD) stale_addr <= pc[31:2];
      if (Exc_Redirect || advance) begin
        bds_pending <= 1'b0;
        br_taken <= 1'b0;
      end else if (ID_IsBranch && !ID_Stall) begin
        // branch left ID before its delay slot was fetched: remember where to go after the slot
        bds_pending <= 1'b1;
        br_taken <= ID_BranchTaken;
        if (ID_BranchTaken) br_target <= ID_BranchTarget;
      end
    end
  end
  // a stale read keeps its original address even though pc already holds the redirect target
  assign InstMem_Read = !reset && (state == DISCARD || (state == REQ && !misaligned));
  assign InstMem_Address = state == DISCARD ? stale_addr : pc[31:2];
  assign IF_Instruction = state == HOLD ? instr : 32'd0;
  assign IF_PC = pc;
  assign IF_PCAdd4 = seq_pc;
  assign IF_IsBDS = ID_IsBranch | bds_pending;
  assign IF_Stall = state != HOLD;
  assign IF_AddrErr = misaligned;
endmodule
